sr_hw_stack: RTL

Parametrised hardware LIFO stack for the schoolRISCV core. It replaces the register-file-resident stack, where the stack pointer indexed the general-purpose registers, with a dedicated storage block.
- Supports push, pop and same-cycle replace-top.
- Tracks occupancy and reports sticky overflow/underflow errors.
- Presents the top entry combinationally, so the single-cycle core can consume it in the same cycle as a POP.

---
 rtl/sr_hw_stack_if.sv | 29 ++
 rtl/sr_hw_stack.sv | 101 ++++++++++
 2 files changed

// File: rtl/sr_hw_stack_if.sv
// Request/status bundle for sr_hw_stack: the core drives through the master modport.
// The stack block attaches through the slave modport.
interface sr_hw_stack_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] top_data;
  logic [AW:0]           count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, push_data, err_clr,
    input  top_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, err_clr,
    output top_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/sr_hw_stack.sv
// Dedicated LIFO stack for the schoolRISCV core, with a combinational top-of-stack read.
// Optional macro SR_HW_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of flagging overflow.
module sr_hw_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic          clk,
  input  logic          rst,
  sr_hw_stack_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_ptr;
  logic [AW:0]           r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic [AW-1:0]         w_top_idx;
  logic                  w_wr_en;
  logic [AW-1:0]         w_wr_idx;
  logic [AW-1:0]         w_ptr_nxt;
  logic [AW:0]           w_count_nxt;
  logic                  w_set_ovf;
  logic                  w_set_udf;

  assign w_empty   = (r_count == CNT_ZERO);
  assign w_full    = (r_count == FULL_CNT);
  assign w_top_idx = r_ptr - PTR_ONE;

  // Operation decode: replace-top has priority, a push+pop on an empty stack degrades to a plain push
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_ptr;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_set_ovf   = 1'b0;
    w_set_udf   = 1'b0;
    if (bus.push && bus.pop && !w_empty) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (bus.push) begin
      if (!w_full) begin
        w_wr_en     = 1'b1;
        w_ptr_nxt   = r_ptr + PTR_ONE;
        w_count_nxt = r_count + CNT_ONE;
      end else begin
`ifdef SR_HW_STACK_WRAP_EN
        w_wr_en   = 1'b1;
        w_ptr_nxt = r_ptr + PTR_ONE;
`else
        w_set_ovf = 1'b1;
`endif
      end
    end else if (bus.pop) begin
      if (!w_empty) begin
        w_ptr_nxt   = r_ptr - PTR_ONE;
        w_count_nxt = r_count - CNT_ONE;
      end else begin
        w_set_udf = 1'b1;
      end
    end else begin
      w_wr_en = 1'b0;
    end
  end

  // Storage array: deliberately not reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= bus.push_data;
    end
  end

  // Pointer, occupancy and sticky error flags; a new error beats err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= {AW{1'b0}};
      r_count     <= CNT_ZERO;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_set_ovf | (r_overflow  & ~bus.err_clr);
      r_underflow <= w_set_udf | (r_underflow & ~bus.err_clr);
    end
  end

  assign bus.top_data  = w_empty ? {DATA_WIDTH{1'b0}} : r_mem[w_top_idx];
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule
